// File: rtl/filter_frame_sequencer.sv
// -----------------------------------------------------------------------------
// filter_frame_sequencer
//
// Frame-level controller in front of a 3x3 line-buffered filter. Accepts an
// upstream pixel stream, drives the filter write strobe and column cursor,
// tracks rows, throws away the outputs produced while the line buffers are
// priming, and delivers the remaining results through a small
// first-word-fall-through FIFO. Upstream acceptance is credit limited so the
// FIFO can never overflow: every pixel in flight through the filter holds one
// credit until its result returns.
//
// Optional build macro: FILTER_SEQ_STALL_CNT_EN
//   When defined, adds stall_cycles_o, a saturating count of cycles in RUN or
//   DRAIN during which the sink held off a valid output.
//
// Ports
//   clk_i           system clock
//   reset_i         asynchronous reset, active low
//   start_i         1-cycle pulse, starts a frame when idle
//   busy_o          high from accepted start until done
//   done_o          1-cycle pulse at frame completion
//   err_o           sticky: FIFO overflow or unexpected flt_d_rdy_i
//   src_data_i      input pixel
//   src_valid_i     source handshake valid
//   src_ready_o     sequencer can accept a pixel
//   flt_d_in_o      pixel to filter
//   flt_wren_o      filter write strobe
//   flt_cursor_o    column index of flt_d_in_o
//   flt_d_out_i     filter result
//   flt_d_rdy_i     filter result valid
//   dst_data_o      filtered pixel (FIFO head)
//   dst_valid_o     FIFO not empty
//   dst_ready_i     sink accepts
//   row_idx_o       row currently being accepted
//   stall_cycles_o  (FILTER_SEQ_STALL_CNT_EN only) sink stall cycle count
//
// States
//   state | meaning
//   IDLE  | waiting for start
//   PRIME | accepting priming rows, results discarded
//   RUN   | accepting remaining rows, results forwarded
//   DRAIN | all pixels accepted, waiting for results and empty FIFO
//   DONE  | one-cycle completion, done_o high
// -----------------------------------------------------------------------------
module filter_frame_sequencer #(
  parameter int BLOCK_LENGTH = 240,
  parameter int FRAME_ROWS   = 240,
  parameter int PRIME_ROWS   = 2,
  parameter int OUT_DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic [15:0] src_data_i,
  input  logic        src_valid_i,
  output logic        src_ready_o,
  output logic [15:0] flt_d_in_o,
  output logic        flt_wren_o,
  output logic [9:0]  flt_cursor_o,
  input  logic [15:0] flt_d_out_i,
  input  logic        flt_d_rdy_i,
  output logic [15:0] dst_data_o,
  output logic        dst_valid_o,
  input  logic        dst_ready_i,
`ifdef FILTER_SEQ_STALL_CNT_EN
  output logic [31:0] stall_cycles_o,
`endif
  output logic [9:0]  row_idx_o
);

  localparam int TOTAL       = FRAME_ROWS * BLOCK_LENGTH;
  localparam int PRIME_TOTAL = PRIME_ROWS * BLOCK_LENGTH;
  localparam int CNT_W       = $clog2(TOTAL + 1);
  localparam int CRW         = $clog2(OUT_DEPTH + 1);
  localparam int PW          = $clog2(OUT_DEPTH);

  localparam logic [CNT_W-1:0] TOTAL_C       = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] PRIME_TOTAL_C = CNT_W'(PRIME_TOTAL);
  localparam logic [CRW-1:0]   DEPTH_N       = CRW'(OUT_DEPTH);
  localparam logic [CRW:0]     DEPTH_W       = (CRW+1)'(OUT_DEPTH);
  localparam logic [9:0]       COL_LAST      = 10'(BLOCK_LENGTH - 1);
  localparam logic [9:0]       ROW_LAST      = 10'(FRAME_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       flt_d_in_q, flt_d_in_d;
  logic              flt_wren_q, flt_wren_d;
  logic [9:0]        cursor_q, cursor_d;
  logic [9:0]        col_q, col_d;
  logic [9:0]        row_q, row_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CRW-1:0]    inflight_q, inflight_d;
  logic [CRW-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [15:0]       mem_q [OUT_DEPTH];

  logic              accept;
  logic              rdy_ok;
  logic              spurious;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              do_write;
  logic              overflow;
  logic              start_acc;
  logic [CRW:0]      credit_used;

`ifdef FILTER_SEQ_STALL_CNT_EN
  logic [31:0]       stall_q, stall_d;
`endif

  // Credits cover both results still inside the filter and entries parked
  // in the FIFO. Priming results also hold a credit until they come back,
  // which keeps the rule uniform across PRIME and RUN.
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
  assign src_ready_o = ((state_q == S_PRIME) || (state_q == S_RUN)) &&
                       (credit_used < DEPTH_W);

  assign dst_valid_o = (fifo_cnt_q != '0);
  assign dst_data_o  = mem_q[rd_ptr_q];

  assign accept    = src_valid_i && src_ready_o;
  assign rdy_ok    = flt_d_rdy_i && (inflight_q != '0);
  assign spurious  = flt_d_rdy_i && (inflight_q == '0);
  assign push      = rdy_ok && (rd_cnt_q >= PRIME_TOTAL_C);
  assign pop       = dst_valid_o && dst_ready_i;
  assign fifo_full = (fifo_cnt_q == DEPTH_N);
  // A pop frees the head slot at the same edge, so full+pop may still write.
  assign do_write  = push && (!fifo_full || pop);
  assign overflow  = push && fifo_full && !pop;
  assign start_acc = start_i && (state_q == S_IDLE);

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    flt_d_in_d = flt_d_in_q;
    flt_wren_d = accept;
    cursor_d   = cursor_q;
    col_d      = col_q;
    row_d      = row_q;
    acc_cnt_d  = acc_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    inflight_d = inflight_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
`ifdef FILTER_SEQ_STALL_CNT_EN
    stall_d    = stall_q;
    if (((state_q == S_RUN) || (state_q == S_DRAIN)) && dst_valid_o &&
        !dst_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
`endif

    if (accept) begin
      flt_d_in_d = src_data_i;
      cursor_d   = col_q;
      acc_cnt_d  = acc_cnt_q + CNT_W'(1);
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q != ROW_LAST) begin
          row_d = row_q + 10'd1;
        end
      end else begin
        col_d = col_q + 10'd1;
      end
    end

    case ({accept, rdy_ok})
      2'b10:   inflight_d = inflight_q + CRW'(1);
      2'b01:   inflight_d = inflight_q - CRW'(1);
      default: inflight_d = inflight_q;
    endcase

    if (rdy_ok) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end

    if (do_write) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_write, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CRW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CRW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (spurious || overflow) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d    = S_PRIME;
          busy_d     = 1'b1;
          err_d      = spurious;
          col_d      = '0;
          row_d      = '0;
          acc_cnt_d  = '0;
          rd_cnt_d   = '0;
          inflight_d = '0;
`ifdef FILTER_SEQ_STALL_CNT_EN
          stall_d    = '0;
`endif
        end
      end
      S_PRIME: begin
        if (acc_cnt_d >= PRIME_TOTAL_C) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (acc_cnt_d == TOTAL_C) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((inflight_q == '0) && (rd_cnt_q == TOTAL_C) && (fifo_cnt_q == '0)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      flt_d_in_q <= '0;
      flt_wren_q <= 1'b0;
      cursor_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      acc_cnt_q  <= '0;
      rd_cnt_q   <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifdef FILTER_SEQ_STALL_CNT_EN
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      flt_d_in_q <= flt_d_in_d;
      flt_wren_q <= flt_wren_d;
      cursor_q   <= cursor_d;
      col_q      <= col_d;
      row_q      <= row_d;
      acc_cnt_q  <= acc_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
`ifdef FILTER_SEQ_STALL_CNT_EN
      stall_q    <= stall_d;
`endif
    end
  end

  // Storage needs no reset: an entry is only visible after it was written.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= flt_d_out_i;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign flt_d_in_o   = flt_d_in_q;
  assign flt_wren_o   = flt_wren_q;
  assign flt_cursor_o = cursor_q;
  assign row_idx_o    = row_q;
`ifdef FILTER_SEQ_STALL_CNT_EN
  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_filter_frame_sequencer.sv
module tb_filter_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [15:0] src_data = '0;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic [15:0] flt_d_in;
  logic        flt_wren;
  logic [9:0]  flt_cursor;
  logic [15:0] flt_d_out;
  logic        flt_d_rdy;
  logic [15:0] dst_data;
  logic        dst_valid;
  logic        dst_ready = 1'b1;
  logic [9:0]  row_idx;
`ifdef FILTER_SEQ_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  filter_frame_sequencer #(
    .BLOCK_LENGTH(4), .FRAME_ROWS(4), .PRIME_ROWS(2), .OUT_DEPTH(4)
  ) dut (
    .clk_i(clk), .reset_i(rst_n), .start_i(start),
    .busy_o(busy), .done_o(done), .err_o(err),
    .src_data_i(src_data), .src_valid_i(src_valid), .src_ready_o(src_ready),
    .flt_d_in_o(flt_d_in), .flt_wren_o(flt_wren), .flt_cursor_o(flt_cursor),
    .flt_d_out_i(flt_d_out), .flt_d_rdy_i(flt_d_rdy),
    .dst_data_o(dst_data), .dst_valid_o(dst_valid), .dst_ready_i(dst_ready),
`ifdef FILTER_SEQ_STALL_CNT_EN
    .stall_cycles_o(stall_cycles),
`endif
    .row_idx_o(row_idx)
  );

  // Filter model: latency 3, result = input + 1. Cleared with the sequencer.
  logic        v1, v2, v3;
  logic [15:0] d1, d2, d3;
  logic        spur = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      d1 <= '0;   d2 <= '0;   d3 <= '0;
    end else begin
      v1 <= flt_wren; d1 <= flt_d_in + 16'd1;
      v2 <= v1;       d2 <= d1;
      v3 <= v2;       d3 <= d2;
    end
  end
  assign flt_d_rdy = v3 | spur;
  assign flt_d_out = d3;

  // Runs one frame from start. Every cycle it checks filter drive, row index,
  // src_ready and dst_valid against a credit/FIFO model, and pops the
  // scoreboard on each output beat. stop_acc>0 returns after that many accepts.
  task automatic run_frame(input bit gaps, input int stall_n, input bit mid_start,
                           input int stop_acc, output int beats, output int dones,
                           output bit saw_full);
    int acc = 0, rd = 0, inf = 0, fifo = 0, cyc = 0;
    bit prev_acc = 0, mid_done = 0, a, d, p, fin = 0;
    int prev_data = 0, prev_col = 0, exp_row;
    logic [15:0] e;
    bit exp_rdy;
    beats = 0; dones = 0; saw_full = 0;
    exp_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%b want=1", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL start_err_clear got=%b want=0", err); end
    while (!fin && cyc < 800) begin
      if (prev_acc) begin
        checks++; if (flt_wren !== 1'b1) begin errors++; $display("FAIL wren_after_accept cyc=%0d got=%b want=1", cyc, flt_wren); end
        checks++; if (flt_d_in !== 16'(prev_data)) begin errors++; $display("FAIL flt_d_in cyc=%0d got=%0d want=%0d", cyc, flt_d_in, prev_data); end
        checks++; if (flt_cursor !== 10'(prev_col)) begin errors++; $display("FAIL cursor cyc=%0d got=%0d want=%0d", cyc, flt_cursor, prev_col); end
      end else begin
        checks++; if (flt_wren !== 1'b0) begin errors++; $display("FAIL wren_no_accept cyc=%0d got=%b want=0", cyc, flt_wren); end
      end
      exp_row = (acc / 4 > 3) ? 3 : acc / 4;
      checks++; if (row_idx !== 10'(exp_row)) begin errors++; $display("FAIL row_idx cyc=%0d got=%0d want=%0d", cyc, row_idx, exp_row); end
      exp_rdy = (acc < 16) && (inf + fifo < 4);
      checks++; if (src_ready !== exp_rdy) begin errors++; $display("FAIL src_ready cyc=%0d got=%b want=%b", cyc, src_ready, exp_rdy); end
      checks++; if (dst_valid !== (fifo > 0)) begin errors++; $display("FAIL dst_valid cyc=%0d got=%b want=%b", cyc, dst_valid, fifo > 0); end
      if (fifo == 4 && src_ready === 1'b0) saw_full = 1;
      if (done === 1'b1) begin
        dones++;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got=%b want=0", busy); end
        fin = 1;
      end else if (stop_acc > 0 && acc >= stop_acc) begin
        fin = 1;
      end else begin
        src_valid = (acc < 16) && (!gaps || (cyc % 2 == 0));
        src_data  = 16'(acc);
        dst_ready = (cyc >= stall_n);
        start     = mid_start && !mid_done && (acc == 10);
        if (start) mid_done = 1;
        a = src_valid && src_ready;
        d = flt_d_rdy;
        p = dst_valid && dst_ready;
        if (p) begin
          beats++;
          if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL unexpected_beat got=%0d want=none", dst_data);
          end else begin
            e = exp_q.pop_front();
            checks++; if (dst_data !== e) begin errors++; $display("FAIL dst_data beat=%0d got=%0d want=%0d", beats, dst_data, e); end
          end
          fifo--;
        end
        if (d) begin
          if (rd >= 8) fifo++;
          rd++; inf--;
        end
        if (a) begin
          if (acc >= 8) exp_q.push_back(16'(acc + 1));
          prev_data = acc; prev_col = acc % 4;
          inf++; acc++;
        end
        prev_acc = a;
        cyc++;
        @(negedge clk);
      end
    end
    src_valid = 1'b0; start = 1'b0; dst_ready = 1'b1;
    if (!fin) begin
      checks++; errors++; $display("FAIL frame_timeout got=no_done want=done");
    end
    if (stop_acc == 0) begin
      repeat (6) begin
        @(negedge clk);
        if (done === 1'b1) dones++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_ctrl got=%b%b%b want=000", busy, done, err); end
    checks++; if (src_ready !== 1'b0 || flt_wren !== 1'b0 || dst_valid !== 1'b0) begin errors++; $display("FAIL reset_hs got=%b%b%b want=000", src_ready, flt_wren, dst_valid); end
    checks++; if (flt_d_in !== 16'd0 || flt_cursor !== 10'd0 || row_idx !== 10'd0) begin errors++; $display("FAIL reset_data got=%0d/%0d/%0d want=0/0/0", flt_d_in, flt_cursor, row_idx); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_continuous();
    int b, dn; bit sf;
    run_frame(0, 0, 0, 0, b, dn, sf);
    checks++; if (b !== 8) begin errors++; $display("FAIL cont_beats got=%0d want=8", b); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL cont_done got=%0d want=1", dn); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL cont_err got=%b want=0", err); end
  endtask

  task automatic test_backpressure();
    int b, dn; bit sf;
    run_frame(0, 60, 0, 0, b, dn, sf);
    checks++; if (sf !== 1'b1) begin errors++; $display("FAIL bp_credit_full got=%b want=1", sf); end
    checks++; if (b !== 8) begin errors++; $display("FAIL bp_beats got=%0d want=8", b); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL bp_err got=%b want=0", err); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_lost got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_gaps();
    int b, dn; bit sf;
    run_frame(1, 0, 0, 0, b, dn, sf);
    checks++; if (b !== 8) begin errors++; $display("FAIL gaps_beats got=%0d want=8", b); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL gaps_done got=%0d want=1", dn); end
  endtask

  task automatic test_start_busy();
    int b, dn; bit sf;
    run_frame(0, 0, 1, 0, b, dn, sf);
    checks++; if (b !== 8) begin errors++; $display("FAIL sb_beats got=%0d want=8", b); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL sb_done got=%0d want=1", dn); end
  endtask

  task automatic test_reset_mid();
    int b, dn; bit sf;
    run_frame(0, 0, 0, 6, b, dn, sf);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || src_ready !== 1'b0 || flt_wren !== 1'b0) begin errors++; $display("FAIL rmid_ctrl got=%b%b%b want=000", busy, src_ready, flt_wren); end
    checks++; if (flt_cursor !== 10'd0 || row_idx !== 10'd0 || flt_d_in !== 16'd0) begin errors++; $display("FAIL rmid_data got=%0d/%0d/%0d want=0/0/0", flt_cursor, row_idx, flt_d_in); end
    checks++; if (dst_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rmid_out got=%b%b want=00", dst_valid, err); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_frame(0, 0, 0, 0, b, dn, sf);
    checks++; if (b !== 8) begin errors++; $display("FAIL rmid_beats got=%0d want=8", b); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL rmid_done got=%0d want=1", dn); end
  endtask

  task automatic test_spurious();
    int b, dn; bit sf;
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_err_set got=%b want=1", err); end
    repeat (5) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_err_sticky got=%b want=1", err); end
    run_frame(0, 0, 0, 0, b, dn, sf);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL spur_err_after got=%b want=0", err); end
    checks++; if (b !== 8) begin errors++; $display("FAIL spur_beats got=%0d want=8", b); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_backpressure();
    test_gaps();
    test_start_busy();
    test_reset_mid();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
